// File: rtl/fetch_dec_queue_pkg.sv
// rtl/fetch_dec_queue_pkg.sv - shared bundle layout for the fetch/decode queue
package fetch_dec_queue_pkg;

  localparam int BUNDLE_W = 196;

  // Bit offsets of each field inside a flattened bundle.
  localparam int PC_LSB   = 0;
  localparam int INST_LSB = 64;
  localparam int RECV_LSB = 128;
  localparam int PRED_LSB = 192;

  // Declared MSB-first so that pc lands at bit 0 and pred at bits 195:192.
  typedef struct packed {
    logic [3:0]  pred;
    logic [63:0] recv_pc;
    logic [63:0] inst;
    logic [63:0] pc;
  } fetch_bundle;

endpackage

// File: rtl/fetch_dec_queue_bundle_fifo_mem.sv
// rtl/fetch_dec_queue_bundle_fifo_mem.sv - bundle storage array, one write port, async read
//
// Ports:
//   clk    - clock
//   we     - write enable; wdata stored at waddr on the rising edge
//   waddr  - write index
//   wdata  - bundle to store
//   raddr  - read index
//   rdata  - bundle at raddr, combinational
// The array is intentionally not reset; the queue's count qualifies its contents.
module bundle_fifo_mem
  import fetch_dec_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  fetch_bundle      wdata,
  input  logic [PTR_W-1:0] raddr,
  output fetch_bundle      rdata
);

  fetch_bundle mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_dec_queue.sv
// rtl/fetch_dec_queue.sv - circular bundle FIFO between fetch and decode
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   fet_vld         - fetch bundle valid
//   fet_pc          - four 16-b PCs {pc3,pc2,pc1,pc0}
//   fet_inst        - four 16-b instructions
//   fet_recv_pc     - four 16-b recovery PCs
//   fet_pred        - per-slot taken prediction
//   has_mispredict  - flush request from the ROB
//   dec_rdy         - decode accepts the head bundle
//   dec_vld         - head bundle valid
//   dec_pc, dec_inst, dec_recv_pc, dec_pred - head bundle fields (zero when empty)
//   stall_fetch     - back-pressure, asserted with SKID slots still free
//   count           - occupied entries
//   overflow        - sticky: a valid bundle arrived while full and was dropped
module fetch_dec_queue
  import fetch_dec_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int SKID  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           fet_vld,
  input  logic [63:0]    fet_pc,
  input  logic [63:0]    fet_inst,
  input  logic [63:0]    fet_recv_pc,
  input  logic [3:0]     fet_pred,
  input  logic           has_mispredict,
  input  logic           dec_rdy,
  output logic           dec_vld,
  output logic [63:0]    dec_pc,
  output logic [63:0]    dec_inst,
  output logic [63:0]    dec_recv_pc,
  output logic [3:0]     dec_pred,
  output logic           stall_fetch,
  output logic [PTR_W:0] count,
  output logic           overflow
);

  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] STALL_CNT = (PTR_W+1)'(DEPTH - SKID);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             enq;
  logic             deq;
  fetch_bundle      wr_bundle;
  fetch_bundle      rd_bundle;
  fetch_bundle      head;

  // A full queue refuses the enqueue even when the head leaves in the same
  // cycle; fetch sees the drop via overflow and must retry.
  assign enq = fet_vld && (count < FULL_CNT) && !has_mispredict;
  assign deq = dec_vld && dec_rdy && !has_mispredict;

  assign wr_bundle = '{pred: fet_pred, recv_pc: fet_recv_pc, inst: fet_inst, pc: fet_pc};

  bundle_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wr_bundle),
    .raddr (rd_ptr),
    .rdata (rd_bundle)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (has_mispredict) begin
      // Flush wins over everything; a bundle arriving now is silently discarded.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are PTR_W bits wide, so the increment wraps modulo DEPTH.
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
      if (fet_vld && (count == FULL_CNT)) begin
        overflow <= 1'b1;
      end
    end
  end

  assign dec_vld     = (count != '0);
  assign stall_fetch = (count >= STALL_CNT);

  // Unwritten or stale entries must never leak out while empty.
  assign head        = dec_vld ? rd_bundle : '0;
  assign dec_pc      = head.pc;
  assign dec_inst    = head.inst;
  assign dec_recv_pc = head.recv_pc;
  assign dec_pred    = head.pred;

endmodule

// File: tb/tb_fetch_dec_queue.sv
// tb/tb_fetch_dec_queue.sv - self-checking bench for fetch_dec_queue
module tb_fetch_dec_queue;
  import fetch_dec_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fet_vld;
  logic [63:0] fet_pc;
  logic [63:0] fet_inst;
  logic [63:0] fet_recv_pc;
  logic [3:0]  fet_pred;
  logic        has_mispredict;
  logic        dec_rdy;
  logic        dec_vld;
  logic [63:0] dec_pc;
  logic [63:0] dec_inst;
  logic [63:0] dec_recv_pc;
  logic [3:0]  dec_pred;
  logic        stall_fetch;
  logic [2:0]  count;
  logic        overflow;

  fetch_dec_queue #(.DEPTH(4), .PTR_W(2), .SKID(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fet_vld        (fet_vld),
    .fet_pc         (fet_pc),
    .fet_inst       (fet_inst),
    .fet_recv_pc    (fet_recv_pc),
    .fet_pred       (fet_pred),
    .has_mispredict (has_mispredict),
    .dec_rdy        (dec_rdy),
    .dec_vld        (dec_vld),
    .dec_pc         (dec_pc),
    .dec_inst       (dec_inst),
    .dec_recv_pc    (dec_recv_pc),
    .dec_pred       (dec_pred),
    .stall_fetch    (stall_fetch),
    .count          (count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered list of held bundles plus the sticky flag.
  fetch_bundle mq[$];
  bit          movf;

  localparam logic [63:0] PC_BASE = 64'h0003_0002_0001_0000;
  localparam logic [63:0] PC_STEP = 64'h0004_0004_0004_0004;

  function automatic logic [63:0] pcn(int k);
    return PC_BASE + 64'(k) * PC_STEP;
  endfunction

  function automatic fetch_bundle mk(logic [63:0] pc);
    fetch_bundle b;
    b.pc      = pc;
    b.inst    = pc ^ 64'hA5A5_5A5A_C3C3_3C3C;
    b.recv_pc = pc + 64'h0010_0010_0010_0010;
    b.pred    = pc[5:2] ^ pc[19:16];
    return b;
  endfunction

  task automatic chk(input string name, input logic [195:0] act, input logic [195:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit vld, input bit rdy, input bit mis, input fetch_bundle b);
    int  sz;
    bit  full;
    bit  take;
    sz = mq.size();
    if (mis) begin
      mq.delete();
    end else begin
      full = (sz == 4);
      take = (sz != 0) && rdy;
      if (vld && full) movf = 1'b1;
      if (take) void'(mq.pop_front());
      if (vld && !full) mq.push_back(b);
    end
  endtask

  task automatic drive_edge(input bit vld, input bit rdy, input bit mis, input fetch_bundle b);
    fet_vld        = vld;
    fet_pc         = b.pc;
    fet_inst       = b.inst;
    fet_recv_pc    = b.recv_pc;
    fet_pred       = b.pred;
    dec_rdy        = rdy;
    has_mispredict = mis;
    model_step(vld, rdy, mis, b);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    fetch_bundle exp_head;
    exp_head = (mq.size() != 0) ? mq[0] : '0;
    chk({tag, "_count"}, 196'(count), 196'(mq.size()));
    chk({tag, "_dec_vld"}, 196'(dec_vld), 196'(mq.size() != 0));
    chk({tag, "_stall"}, 196'(stall_fetch), 196'(mq.size() >= 3));
    chk({tag, "_overflow"}, 196'(overflow), 196'(movf));
    chk({tag, "_head"}, {dec_pred, dec_recv_pc, dec_inst, dec_pc}, exp_head);
  endtask

  typedef struct {
    bit vld;
    bit rdy;
    bit mis;
    int pc_idx;
    int exp_cnt;
    bit exp_vld;
    bit exp_stall;
    bit exp_ovf;
    int exp_idx;   // -1: head must read as zero
  } tvec_t;

  function automatic tvec_t tv_mk(bit v, bit r, bit m, int pi, int c, bit dv, bit st, bit ov, int ei);
    tvec_t t;
    t.vld = v; t.rdy = r; t.mis = m; t.pc_idx = pi;
    t.exp_cnt = c; t.exp_vld = dv; t.exp_stall = st; t.exp_ovf = ov; t.exp_idx = ei;
    return t;
  endfunction

  tvec_t tv[17];

  initial begin
    logic [63:0] exp_pc;
    int          sent;
    int          rx;
    bit          vld;
    bit          rdy;
    bit          mis;
    fetch_bundle b;

    rst_n = 1'b0;
    fet_vld = 1'b0; fet_pc = '0; fet_inst = '0; fet_recv_pc = '0; fet_pred = '0;
    has_mispredict = 1'b0; dec_rdy = 1'b0;
    mq.delete(); movf = 1'b0;

    #12;
    chk("rst_count", 196'(count), 196'(0));
    chk("rst_dec_vld", 196'(dec_vld), 196'(0));
    chk("rst_stall", 196'(stall_fetch), 196'(0));
    chk("rst_overflow", 196'(overflow), 196'(0));
    chk("rst_dec_data", {dec_pred, dec_recv_pc, dec_inst, dec_pc}, 196'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed fill / overflow / simultaneous enq-deq / flush scenario.
    tv[0]  = tv_mk(1, 0, 0, 0,  1, 1, 0, 0, 0);
    tv[1]  = tv_mk(1, 0, 0, 1,  2, 1, 0, 0, 0);
    tv[2]  = tv_mk(1, 0, 0, 2,  3, 1, 1, 0, 0);
    tv[3]  = tv_mk(1, 0, 0, 3,  4, 1, 1, 0, 0);
    tv[4]  = tv_mk(1, 0, 0, 4,  4, 1, 1, 1, 0);
    tv[5]  = tv_mk(1, 1, 0, 5,  3, 1, 1, 1, 1);
    tv[6]  = tv_mk(0, 1, 0, 0,  2, 1, 0, 1, 2);
    tv[7]  = tv_mk(1, 1, 0, 6,  2, 1, 0, 1, 3);
    tv[8]  = tv_mk(0, 1, 0, 0,  1, 1, 0, 1, 6);
    tv[9]  = tv_mk(0, 1, 0, 0,  0, 0, 0, 1, -1);
    tv[10] = tv_mk(1, 0, 0, 7,  1, 1, 0, 1, 7);
    tv[11] = tv_mk(1, 0, 0, 8,  2, 1, 0, 1, 7);
    tv[12] = tv_mk(1, 0, 0, 9,  3, 1, 1, 1, 7);
    tv[13] = tv_mk(1, 1, 1, 10, 0, 0, 0, 1, -1);
    tv[14] = tv_mk(1, 1, 1, 11, 0, 0, 0, 1, -1);
    tv[15] = tv_mk(1, 0, 0, 12, 1, 1, 0, 1, 12);
    tv[16] = tv_mk(0, 1, 0, 0,  0, 0, 0, 1, -1);

    for (int i = 0; i < 17; i++) begin
      drive_edge(tv[i].vld, tv[i].rdy, tv[i].mis, mk(pcn(tv[i].pc_idx)));
      exp_pc = (tv[i].exp_idx < 0) ? 64'h0 : pcn(tv[i].exp_idx);
      chk($sformatf("tv%0d_count", i), 196'(count), 196'(tv[i].exp_cnt));
      chk($sformatf("tv%0d_dec_vld", i), 196'(dec_vld), 196'(tv[i].exp_vld));
      chk($sformatf("tv%0d_stall", i), 196'(stall_fetch), 196'(tv[i].exp_stall));
      chk($sformatf("tv%0d_overflow", i), 196'(overflow), 196'(tv[i].exp_ovf));
      chk($sformatf("tv%0d_dec_pc", i), 196'(dec_pc), 196'(exp_pc));
    end

    // Asynchronous reset mid-stream with two bundles held.
    drive_edge(1, 0, 0, mk(pcn(40)));
    drive_edge(1, 0, 0, mk(pcn(41)));
    check_model("pre_arst");
    fet_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete(); movf = 1'b0;
    chk("arst_dec_vld", 196'(dec_vld), 196'(0));
    chk("arst_count", 196'(count), 196'(0));
    chk("arst_stall", 196'(stall_fetch), 196'(0));
    chk("arst_overflow", 196'(overflow), 196'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // No bypass: an enqueue is not visible until after the edge.
    b = mk(pcn(50));
    fet_vld = 1'b1; fet_pc = b.pc; fet_inst = b.inst; fet_recv_pc = b.recv_pc; fet_pred = b.pred;
    #1;
    chk("nobypass_dec_vld", 196'(dec_vld), 196'(0));
    drive_edge(1, 0, 0, b);
    check_model("nobypass_after");
    drive_edge(0, 1, 0, mk(64'h0));
    check_model("nobypass_drain");

    // Stream 10 bundles, fetch honours stall_fetch, decode ready toggles.
    sent = 0;
    rx   = 0;
    for (int cyc = 0; cyc < 200 && rx < 10; cyc++) begin
      rdy = (cyc % 2) == 0;
      vld = !stall_fetch && (sent < 10);
      if (dec_vld && rdy) begin
        chk($sformatf("stream_rx%0d", rx), 196'(dec_pc), 196'(pcn(100 + rx)));
        rx++;
      end
      drive_edge(vld, rdy, 0, mk(pcn(100 + sent)));
      if (vld) sent++;
      check_model("stream");
    end
    chk("stream_received", 196'(rx), 196'(10));
    chk("stream_no_overflow", 196'(overflow), 196'(0));

    // Randomised traffic against the model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      vld = ($urandom % 4) != 0;
      rdy = ($urandom % 2) != 0;
      mis = ($urandom % 16) == 0;
      b.pc      = {$urandom, $urandom};
      b.inst    = {$urandom, $urandom};
      b.recv_pc = {$urandom, $urandom};
      b.pred    = 4'($urandom);
      drive_edge(vld, rdy, mis, b);
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
